// File: rtl/ysyx_22041211_fetch_seq.sv
// Multi-cycle fetch sequencer that owns the architectural PC.
// It fetches one instruction, holds it until the EXU finishes, then commits the next PC.
module ysyx_22041211_fetch_seq #(
    parameter int                    ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0]   RESET_PC = 32'h8000_0000,
    parameter int                    TIMEOUT  = 255,
    parameter int                    CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_LEN-1:0] ifu_araddr_o,
    output logic                ifu_arvalid_o,
    input  logic                ifu_arready_i,
    input  logic [31:0]         ifu_rdata_i,
    input  logic [1:0]          ifu_rresp_i,
    input  logic                ifu_rvalid_i,
    output logic                ifu_rready_o,
    output logic [31:0]         inst_o,
    output logic                inst_valid_o,
    input  logic                exu_done_i,
    input  logic                branch_request_i,
    input  logic                branch_flag_i,
    input  logic [ADDR_LEN-1:0] branch_target_i,
    input  logic                jmp_flag_i,
    input  logic [ADDR_LEN-1:0] jmp_target_i,
    input  logic                csr_jmp_i,
    input  logic [ADDR_LEN-1:0] csr_pc_i,
    input  logic                halt_i,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [ADDR_LEN-1:0] dnpc_o,
    output logic                retire_o,
    output logic                fetch_err_o,
    output logic                timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_EX,
        S_HALT
    } state_t;

    state_t              state, nxt;
    logic [ADDR_LEN-1:0] pc_q;
    logic [CNT_W-1:0]    wdog, wdog_nxt;
    logic                expire;
    logic                rd_fire, rd_ok, done_fire, misalign;
    logic                ev_commit, ev_misal, ev_rerr, ev_timeout;

    // Redirect priority: taken branch, then jump, then CSR trap/return, else sequential.
    always_comb begin
        if (branch_request_i && branch_flag_i) dnpc_o = branch_target_i;
        else if (jmp_flag_i)                   dnpc_o = jmp_target_i;
        else if (csr_jmp_i)                    dnpc_o = csr_pc_i;
        else                                   dnpc_o = pc_q + ADDR_LEN'(4);
    end

    assign misalign  = |dnpc_o[1:0];
    assign wdog_nxt  = wdog + CNT_W'(1);
    assign expire    = (TIMEOUT != 0) && (wdog_nxt == CNT_W'(TIMEOUT));
    assign rd_fire   = (state == S_R) && ifu_rvalid_i;
    assign rd_ok     = rd_fire && (ifu_rresp_i == 2'b00);
    assign done_fire = (state == S_EX) && exu_done_i;

    assign ev_commit  = done_fire && !misalign;
    assign ev_misal   = done_fire && misalign;
    assign ev_rerr    = rd_fire && (ifu_rresp_i != 2'b00);
    // Data arriving on the expiry cycle takes precedence over the watchdog.
    assign ev_timeout = expire && ((state == S_AR) || ((state == S_R) && !ifu_rvalid_i));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: nxt = S_AR;
            S_AR: begin
                if (ev_timeout)         nxt = S_HALT;
                else if (ifu_arready_i) nxt = S_R;
            end
            S_R: begin
                if (rd_ok)                   nxt = S_EX;
                else if (ev_rerr || ev_timeout) nxt = S_HALT;
            end
            S_EX: begin
                if (done_fire) nxt = (misalign || halt_i) ? S_HALT : S_AR;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc_q          <= RESET_PC;
            inst_o        <= 32'h0;
            wdog          <= '0;
            ifu_arvalid_o <= 1'b0;
            ifu_rready_o  <= 1'b0;
            inst_valid_o  <= 1'b0;
            retire_o      <= 1'b0;
            fetch_err_o   <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= nxt;
            ifu_arvalid_o <= (nxt == S_AR);
            ifu_rready_o  <= (nxt == S_R);
            inst_valid_o  <= (nxt == S_EX);
            retire_o      <= ev_commit;
            fetch_err_o   <= ev_rerr || ev_misal;
            if (ev_timeout) timeout_o <= 1'b1;
            if (ev_commit)  pc_q      <= dnpc_o;
            if (rd_ok)      inst_o    <= ifu_rdata_i;
            // Watchdog spans the whole address+data phase of one fetch.
            if (nxt == S_AR && state != S_AR)     wdog <= '0;
            else if (state == S_AR || state == S_R) wdog <= wdog_nxt;
        end
    end

    assign pc_o         = pc_q;
    assign ifu_araddr_o = pc_q;

endmodule

// File: tb/tb_ysyx_22041211_fetch_seq.sv
// Bench for the fetch sequencer: expected fetch addresses are queued at commit time and
// compared when the address handshake is observed.
module tb_ysyx_22041211_fetch_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exu_done, br_req, br_flag, jmp_flag, csr_jmp, halt;
    logic [31:0] br_tgt, jmp_tgt, csr_pc;
    logic [31:0] pc, dnpc;
    logic        retire, fetch_err, timeout;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pc_m;

    ysyx_22041211_fetch_seq #(
        .ADDR_LEN(32), .RESET_PC(RST_PC), .TIMEOUT(8), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr_o(araddr), .ifu_arvalid_o(arvalid), .ifu_arready_i(arready),
        .ifu_rdata_i(rdata), .ifu_rresp_i(rresp), .ifu_rvalid_i(rvalid), .ifu_rready_o(rready),
        .inst_o(inst), .inst_valid_o(inst_valid), .exu_done_i(exu_done),
        .branch_request_i(br_req), .branch_flag_i(br_flag), .branch_target_i(br_tgt),
        .jmp_flag_i(jmp_flag), .jmp_target_i(jmp_tgt), .csr_jmp_i(csr_jmp), .csr_pc_i(csr_pc),
        .halt_i(halt), .pc_o(pc), .dnpc_o(dnpc), .retire_o(retire),
        .fetch_err_o(fetch_err), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: every accepted fetch address must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && arvalid && arready) begin
            if (exp_q.size() == 0) chk("araddr_unexpected", 64'(exp_q.size()), 64'd1);
            else                   chk("araddr", araddr, exp_q.pop_front());
        end
    end

    function automatic logic [31:0] ref_dnpc(input logic [31:0] cur, input bit br, input bit bf,
                                             input logic [31:0] bt, input bit jf, input logic [31:0] jt,
                                             input bit cj, input logic [31:0] cp);
        if (br && bf) return bt;
        if (jf)       return jt;
        if (cj)       return cp;
        return cur + 32'd4;
    endfunction

    task automatic clear_redirect();
        exu_done = 0; br_req = 0; br_flag = 0; jmp_flag = 0; csr_jmp = 0; halt = 0;
        br_tgt = 0; jmp_tgt = 0; csr_pc = 0;
    endtask

    task automatic wait_ex(input string tag);
        int n = 0;
        while (!inst_valid && n < 40) begin tick(); n++; end
        chk({tag, "_ex_reached"}, 64'(inst_valid), 64'd1);
    endtask

    task automatic commit(input bit br, input bit bf, input logic [31:0] bt, input bit jf,
                          input logic [31:0] jt, input bit cj, input logic [31:0] cp, input bit hl);
        logic [31:0] e;
        e = ref_dnpc(pc_m, br, bf, bt, jf, jt, cj, cp);
        br_req = br; br_flag = bf; br_tgt = bt; jmp_flag = jf; jmp_tgt = jt;
        csr_jmp = cj; csr_pc = cp; halt = hl; exu_done = 1;
        #1 chk("dnpc", dnpc, e);
        if (!hl) exp_q.push_back(e);
        tick();
        clear_redirect();
        chk("retire_pulse", 64'(retire), 64'd1);
        chk("pc_commit", pc, e);
        pc_m = e;
        tick();
        chk("retire_single", 64'(retire), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        tick(); tick();
        pc_m = RST_PC;
        exp_q.push_back(RST_PC);
        rst = 0;
    endtask

    initial begin
        rst = 1; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        clear_redirect();
        pc_m = RST_PC;
        tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_fetch_err", 64'(fetch_err), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);

        // Sequential stream with an always-ready memory.
        exp_q.push_back(RST_PC);
        arready = 1; rvalid = 1; rdata = 32'h0000_0013;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ex("seq");
            chk("seq_inst", inst, rdata);
            commit(0, 0, 0, 0, 0, 0, 0, 0);
            rdata = rdata + 32'h80;
        end

        wait_ex("prio_all");
        commit(1, 1, 32'h8000_0100, 1, 32'h8000_0200, 1, 32'h8000_0300, 0);
        wait_ex("prio_jmp");
        commit(1, 0, 32'h8000_0500, 1, 32'h8000_0200, 1, 32'h8000_0300, 0);
        wait_ex("prio_csr");
        commit(0, 1, 32'h8000_0600, 0, 32'h8000_0700, 1, 32'h8000_0300, 0);

        // pc+4 wraps at the top of the address space.
        wait_ex("wrap_a");
        commit(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        wait_ex("wrap_b");
        commit(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        // halt_i still retires and updates the PC, then fetching stops.
        wait_ex("halt");
        commit(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) tick();
        exu_done = 1;
        tick(); tick();
        exu_done = 0;
        chk("halt_arvalid", 64'(arvalid), 64'd0);
        chk("halt_inst_valid", 64'(inst_valid), 64'd0);
        chk("halt_retire", 64'(retire), 64'd0);
        chk("halt_pc", pc, 32'h4);

        // Misaligned jump target at commit.
        do_reset();
        wait_ex("misal");
        jmp_flag = 1; jmp_tgt = 32'h8000_0002; exu_done = 1;
        tick();
        clear_redirect();
        chk("misal_err", 64'(fetch_err), 64'd1);
        chk("misal_retire", 64'(retire), 64'd0);
        chk("misal_pc", pc, RST_PC);
        tick();
        chk("misal_err_pulse", 64'(fetch_err), 64'd0);
        repeat (4) tick();
        chk("misal_halt_arvalid", 64'(arvalid), 64'd0);
        chk("misal_halt_inst_valid", 64'(inst_valid), 64'd0);

        // Reset while a read response is pending in S_R.
        rdata = 32'h0000_0013;
        do_reset();
        wait_ex("mid_a");
        rvalid = 0;
        commit(0, 0, 0, 0, 0, 0, 0, 0);
        begin
            int n = 0;
            while (!rready && n < 20) begin tick(); n++; end
        end
        chk("mid_in_r", 64'(rready), 64'd1);
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        #2 rst = 1;
        #1;
        chk("mid_rst_rready", 64'(rready), 64'd0);
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        pc_m = RST_PC;
        exp_q.push_back(RST_PC);
        rst = 0;
        wait_ex("mid_restart");
        chk("mid_restart_inst", inst, 32'hDEAD_BEEF);
        chk("mid_restart_pc", pc, RST_PC);

        // Error response on the first fetch.
        rresp = 2'b10; rdata = 32'h0000_0013;
        do_reset();
        begin
            int  n = 0;
            bit  saw_iv = 0;
            while (!fetch_err && n < 20) begin
                tick(); n++;
                if (inst_valid) saw_iv = 1;
            end
            chk("rresp_err", 64'(fetch_err), 64'd1);
            chk("rresp_pc", pc, RST_PC);
            tick();
            chk("rresp_err_pulse", 64'(fetch_err), 64'd0);
            repeat (4) begin tick(); if (inst_valid) saw_iv = 1; end
            chk("rresp_no_inst_valid", 64'(saw_iv), 64'd0);
            chk("rresp_halt_arvalid", 64'(arvalid), 64'd0);
        end

        // Watchdog: address never accepted.
        rresp = 0; arready = 0; rvalid = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        begin
            int n = 0;
            for (int k = 0; k < 30; k++) begin
                tick();
                if (timeout) break;
                if (arvalid) n++;
            end
            chk("wdog_cycles", 64'(n), 64'd8);
            chk("wdog_timeout", 64'(timeout), 64'd1);
            chk("wdog_arvalid", 64'(arvalid), 64'd0);
        end
        arready = 1;
        repeat (4) tick();
        chk("wdog_sticky", 64'(timeout), 64'd1);
        chk("wdog_halt_arvalid", 64'(arvalid), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
